// File: rtl/hni_qos_req_issue.sv
// Pending-request tracker and issue FSM for HNI RNF MSHR entries.
// Pending entries are offered to an external selector; the chosen entry is issued downstream with a valid/ready handshake.
module hni_qos_req_issue #(
  parameter int HNI_MSHR_RNF_NUM_PARAM = 16,
  localparam int ENTRIES_NUM = HNI_MSHR_RNF_NUM_PARAM,
  localparam int IDX_W = (ENTRIES_NUM > 1) ? $clog2(ENTRIES_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [IDX_W-1:0]       alloc_entry,
  output logic [ENTRIES_NUM-1:0] req_entry_vec,
  output logic                   upd_start_entry,
  input  logic [ENTRIES_NUM-1:0] req_entry_ptr_sel,
  output logic                   issue_valid,
  output logic [IDX_W-1:0]       issue_entry_idx,
  input  logic                   issue_ready,
  output logic                   alloc_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEL   = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [IDX_W:0] ENTRIES_LIM = (IDX_W + 1)'(ENTRIES_NUM);

  logic [1:0]             state_q;
  logic [ENTRIES_NUM-1:0] pending_q;
  logic [ENTRIES_NUM-1:0] set_mask;
  logic [ENTRIES_NUM-1:0] clr_mask;
  logic [ENTRIES_NUM-1:0] pending_cleared;
  logic [IDX_W-1:0]       sel_idx;
  logic                   alloc_in_range;
  logic                   alloc_dup;
  logic                   handshake;

  assign alloc_in_range  = ({1'b0, alloc_entry} < ENTRIES_LIM);
  assign handshake       = issue_valid & issue_ready;
  assign req_entry_vec   = pending_q;
  assign issue_valid     = (state_q == ISSUE);
  assign upd_start_entry = (state_q == IDLE) & (|pending_q);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (alloc_valid && alloc_in_range) set_mask[alloc_entry] = 1'b1;
    if (handshake) clr_mask[issue_entry_idx] = 1'b1;
  end

  // The issue clear is applied first, so an alloc to the entry being retired is legal and re-arms it.
  assign pending_cleared = pending_q & ~clr_mask;
  assign alloc_dup       = alloc_valid & alloc_in_range & (|(pending_cleared & set_mask));

  always_comb begin
    sel_idx = '0;
    for (int i = ENTRIES_NUM - 1; i >= 0; i--) begin
      if (req_entry_ptr_sel[i]) sel_idx = i[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      alloc_err <= 1'b0;
    end else begin
      pending_q <= pending_cleared | set_mask;
      if (alloc_dup) alloc_err <= 1'b1;
    end
  end

  // One selector strobe per round; an empty selection abandons the round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      issue_entry_idx <= '0;
    end else begin
      case (state_q)
        IDLE: if (|pending_q) state_q <= SEL;
        SEL: begin
          if (|req_entry_ptr_sel) begin
            issue_entry_idx <= sel_idx;
            state_q         <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: if (issue_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hni_qos_req_issue.sv
// Directed bench for hni_qos_req_issue with four entries and a small selector model.
// Each table row drives one cycle of inputs and lists the outputs expected during that cycle.
module tb_hni_qos_req_issue;

  logic       clk;
  logic       rst;
  logic       alloc_valid;
  logic [1:0] alloc_entry;
  logic [3:0] req_entry_vec;
  logic       upd_start_entry;
  logic [3:0] req_entry_ptr_sel;
  logic       issue_valid;
  logic [1:0] issue_entry_idx;
  logic       issue_ready;
  logic       alloc_err;

  logic       sel_ovr;
  logic [3:0] sel_val;
  logic [3:0] sel_reg;

  int total;
  int bad;
  int step;

  typedef struct {
    logic       alloc_valid;
    logic [1:0] alloc_entry;
    logic       issue_ready;
    logic       sel_ovr;
    logic [3:0] sel_val;
    logic [3:0] exp_pending;
    logic       exp_upd;
    logic       exp_iv;
    logic [1:0] exp_idx;
    logic       exp_err;
  } vec_t;

  vec_t vecs[27];

  hni_qos_req_issue #(.HNI_MSHR_RNF_NUM_PARAM(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_valid       (alloc_valid),
    .alloc_entry       (alloc_entry),
    .req_entry_vec     (req_entry_vec),
    .upd_start_entry   (upd_start_entry),
    .req_entry_ptr_sel (req_entry_ptr_sel),
    .issue_valid       (issue_valid),
    .issue_entry_idx   (issue_entry_idx),
    .issue_ready       (issue_ready),
    .alloc_err         (alloc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector model: samples the pending vector on the strobe and returns its lowest set bit next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_reg <= 4'b0000;
    else if (upd_start_entry) sel_reg <= req_entry_vec & (~req_entry_vec + 4'd1);
  end

  assign req_entry_ptr_sel = sel_ovr ? sel_val : sel_reg;

  function automatic vec_t mk(logic av, logic [1:0] ae, logic rdy, logic so, logic [3:0] sv,
                              logic [3:0] ep, logic eu, logic ei, logic [1:0] ex, logic ee);
    vec_t v;
    v.alloc_valid = av; v.alloc_entry = ae; v.issue_ready = rdy;
    v.sel_ovr = so; v.sel_val = sv;
    v.exp_pending = ep; v.exp_upd = eu; v.exp_iv = ei; v.exp_idx = ex; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    check("pending", int'(req_entry_vec), int'(v.exp_pending));
    check("upd_start_entry", int'(upd_start_entry), int'(v.exp_upd));
    check("issue_valid", int'(issue_valid), int'(v.exp_iv));
    check("alloc_err", int'(alloc_err), int'(v.exp_err));
    if (v.exp_iv) check("issue_entry_idx", int'(issue_entry_idx), int'(v.exp_idx));
  endtask

  task automatic applyStimulus(input vec_t v);
    alloc_valid = v.alloc_valid;
    alloc_entry = v.alloc_entry;
    issue_ready = v.issue_ready;
    sel_ovr     = v.sel_ovr;
    sel_val     = v.sel_val;
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
    step++;
  endtask

  initial begin
    total = 0; bad = 0; step = 0;
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_entry = 2'd0; issue_ready = 1'b0;
    sel_ovr = 1'b0; sel_val = 4'b0000;

    //                 av  ae  rdy ovr sel      pend     upd iv idx err
    vecs[0]  = mk(1, 2, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 4'b0000, 4'b0100, 0, 1, 2, 0);
    vecs[4]  = mk(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, 1, 0, 4'b0000, 4'b0010, 0, 1, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 4'b0000, 4'b0010, 0, 0, 0, 0);
    vecs[19] = mk(1, 3, 0, 0, 4'b0000, 4'b0010, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 4'b1010, 4'b1010, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 4'b0000, 4'b1010, 0, 1, 1, 0);
    vecs[22] = mk(1, 3, 0, 0, 4'b0000, 4'b1000, 1, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 0, 1);
    vecs[24] = mk(0, 0, 1, 0, 4'b0000, 4'b1000, 0, 1, 3, 1);
    vecs[25] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vecs[26] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

    @(posedge clk);
    #1;
    check("reset_pending", int'(req_entry_vec), 0);
    check("reset_issue_valid", int'(issue_valid), 0);
    check("reset_upd", int'(upd_start_entry), 0);
    check("reset_alloc_err", int'(alloc_err), 0);
    check("reset_idx", int'(issue_entry_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 27; i++) applyStimulus(vecs[i]);

    // Sticky error clears only on reset, and reset acts without a clock edge.
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", int'(alloc_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Drive a round into ISSUE, then reset asynchronously mid-cycle.
    applyStimulus(mk(1, 2, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 4'b0000, 4'b0110, 0, 0, 0, 0));
    check("pre_rst_issue_valid", int'(issue_valid), 1);
    check("pre_rst_idx", int'(issue_entry_idx), 2);
    rst = 1'b1;
    #1;
    check("async_rst_issue_valid", int'(issue_valid), 0);
    check("async_rst_pending", int'(req_entry_vec), 0);
    check("async_rst_upd", int'(upd_start_entry), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    applyStimulus(mk(1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 4'b0000, 4'b0010, 0, 1, 1, 0));
    applyStimulus(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
